// File: rtl/tmp101_reading_sequencer.sv
// Periodic TMP101 reader: pulses Go, collects MSB/LSB, converts to sign + BCD digits.
// Optional macro TMP101_TENTHS_EN enables the fractional tenths digit.
module tmp101_reading_sequencer #(
    parameter int unsigned ClockFrequency = 60000000,
    parameter int unsigned SampleRate     = 4,
    parameter int unsigned TimeoutCycles  = 200000
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic        Enable,
    output logic        Go,
    input  logic        ByteValid,
    input  logic [7:0]  ReceivedData,
    input  logic        TransferDone,
    output logic [11:0] RawTemp,
    output logic        Sign,
    output logic [3:0]  HundredsBCD,
    output logic [3:0]  TensBCD,
    output logic [3:0]  OnesBCD,
    output logic [3:0]  TenthsBCD,
    output logic        SampleValid,
    output logic        TimeoutError
);

    localparam int unsigned Period   = ClockFrequency / SampleRate;
    localparam int unsigned PeriodW  = (Period > 1) ? $clog2(Period) : 1;
    localparam int unsigned TimeoutW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int unsigned DabW     = 20;
    localparam int unsigned BitCntW  = 3;

    typedef enum logic [2:0] {
        IDLE, START, WAIT_MSB, WAIT_LSB, WAIT_DONE, CONVERT, BCD, PUBLISH
    } state_t;

    state_t               state, state_next;
    logic [PeriodW-1:0]   period_cnt;
    logic [TimeoutW-1:0]  to_cnt;
    logic [BitCntW-1:0]   bit_cnt;
    logic [7:0]           msb_q, lsb_q;
    logic [11:0]          raw_q;
    logic [DabW-1:0]      dab_q, dab_adj_c, dab_step_c;
    logic [11:0]          raw_c, mag_c;
    logic                 tick_c, waiting_c, to_expired_c, abort_c;

    assign tick_c       = Enable && (period_cnt == PeriodW'(Period - 1));
    assign waiting_c    = (state == WAIT_MSB) || (state == WAIT_LSB) || (state == WAIT_DONE);
    assign to_expired_c = waiting_c && (to_cnt == TimeoutW'(TimeoutCycles - 1));
    assign raw_c        = {msb_q, lsb_q[7:4]};
    assign mag_c        = raw_c[11] ? 12'(~raw_c + 12'd1) : raw_c;

    // One double-dabble iteration: add 3 to any digit >= 5, then shift left.
    always_comb begin
        dab_adj_c = dab_q;
        for (int d = 0; d < 3; d++) begin
            if (dab_q[8 + 4*d +: 4] >= 4'd5) begin
                dab_adj_c[8 + 4*d +: 4] = dab_q[8 + 4*d +: 4] + 4'd3;
            end
        end
        dab_step_c = {dab_adj_c[DabW-2:0], 1'b0};
    end

`ifdef TMP101_TENTHS_EN
    logic [3:0] frac_q;
    logic [7:0] tenths_prod_c;
    logic       unused_bits;
    assign tenths_prod_c = {4'd0, frac_q} * 8'd10;
    assign unused_bits   = ^{lsb_q[3:0], tenths_prod_c[3:0]};
`else
    logic unused_bits;
    assign TenthsBCD   = 4'd0;
    assign unused_bits = ^{lsb_q[3:0], mag_c[3:0]};
`endif

    always_ff @(posedge clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        abort_c    = 1'b0;
        case (state)
            IDLE:      if (tick_c) state_next = START;
            START:     state_next = WAIT_MSB;
            WAIT_MSB: begin
                if (ByteValid) begin
                    state_next = WAIT_LSB;
                end else if (TransferDone || to_expired_c) begin
                    state_next = IDLE;
                    abort_c    = 1'b1;
                end
            end
            WAIT_LSB: begin
                if (ByteValid) begin
                    state_next = TransferDone ? CONVERT : WAIT_DONE;
                end else if (to_expired_c) begin
                    state_next = IDLE;
                    abort_c    = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (TransferDone) begin
                    state_next = CONVERT;
                end else if (to_expired_c) begin
                    state_next = IDLE;
                    abort_c    = 1'b1;
                end
            end
            CONVERT:   state_next = BCD;
            BCD:       if (bit_cnt == BitCntW'(7)) state_next = PUBLISH;
            PUBLISH:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Free-running sample period counter, held at zero while disabled.
    always_ff @(posedge clock) begin
        if (Reset || !Enable || tick_c) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PeriodW'(1);
        end
    end

    // Datapath and registered outputs; results surface together with SampleValid.
    always_ff @(posedge clock) begin
        if (Reset) begin
            to_cnt       <= '0;
            bit_cnt      <= '0;
            msb_q        <= '0;
            lsb_q        <= '0;
            raw_q        <= '0;
            dab_q        <= '0;
            Go           <= 1'b0;
            SampleValid  <= 1'b0;
            TimeoutError <= 1'b0;
            RawTemp      <= '0;
            Sign         <= 1'b0;
            HundredsBCD  <= '0;
            TensBCD      <= '0;
            OnesBCD      <= '0;
`ifdef TMP101_TENTHS_EN
            frac_q       <= '0;
            TenthsBCD    <= '0;
`endif
        end else begin
            Go          <= (state_next == START);
            SampleValid <= (state_next == PUBLISH);

            if (state_next != state) begin
                to_cnt <= '0;
            end else if (waiting_c) begin
                to_cnt <= to_cnt + TimeoutW'(1);
            end

            if (state == WAIT_MSB && ByteValid) msb_q <= ReceivedData;
            if (state == WAIT_LSB && ByteValid) lsb_q <= ReceivedData;

            if (state == CONVERT) begin
                raw_q   <= raw_c;
                dab_q   <= {12'd0, mag_c[11:4]};
                bit_cnt <= '0;
`ifdef TMP101_TENTHS_EN
                frac_q  <= mag_c[3:0];
`endif
            end

            if (state == BCD) begin
                dab_q   <= dab_step_c;
                bit_cnt <= bit_cnt + BitCntW'(1);
            end

            if (state_next == PUBLISH) begin
                RawTemp      <= raw_q;
                Sign         <= raw_q[11];
                HundredsBCD  <= dab_step_c[19:16];
                TensBCD      <= dab_step_c[15:12];
                OnesBCD      <= dab_step_c[11:8];
                TimeoutError <= 1'b0;
`ifdef TMP101_TENTHS_EN
                TenthsBCD    <= tenths_prod_c[7:4];
`endif
            end else if (abort_c) begin
                TimeoutError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tmp101_reading_sequencer.sv
// Directed bench for tmp101_reading_sequencer: vector table plus corner-case sequences.
module tb_tmp101_reading_sequencer;

    localparam int unsigned ClkHz   = 400;
    localparam int unsigned Rate    = 4;
    localparam int unsigned Tmo     = 60;
    localparam int          PERIOD  = 100;

    logic        clock = 1'b0;
    logic        Reset, Enable, ByteValid, TransferDone;
    logic [7:0]  ReceivedData;
    logic        Go, Sign, SampleValid, TimeoutError;
    logic [11:0] RawTemp;
    logic [3:0]  HundredsBCD, TensBCD, OnesBCD, TenthsBCD;

    int n_checks = 0;
    int n_fail   = 0;

    tmp101_reading_sequencer #(
        .ClockFrequency(ClkHz),
        .SampleRate    (Rate),
        .TimeoutCycles (Tmo)
    ) dut (
        .clock       (clock),
        .Reset       (Reset),
        .Enable      (Enable),
        .Go          (Go),
        .ByteValid   (ByteValid),
        .ReceivedData(ReceivedData),
        .TransferDone(TransferDone),
        .RawTemp     (RawTemp),
        .Sign        (Sign),
        .HundredsBCD (HundredsBCD),
        .TensBCD     (TensBCD),
        .OnesBCD     (OnesBCD),
        .TenthsBCD   (TenthsBCD),
        .SampleValid (SampleValid),
        .TimeoutError(TimeoutError)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  msb;
        logic [7:0]  lsb;
        bit          same;
        bit          extra;
        logic [11:0] raw;
        logic        sign;
        logic [3:0]  h, t, o, ten;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [3:0] exp_ten(input logic [3:0] ten);
`ifdef TMP101_TENTHS_EN
        return ten;
`else
        return 4'd0 & ten;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for Go with a cycle budget; n = edges counted, sv = SampleValid seen meanwhile.
    task automatic wait_go(output int n, output bit sv);
        n  = 0;
        sv = 0;
        while (n < 2 * PERIOD) begin
            @(posedge clock); #1;
            n++;
            if (SampleValid) sv = 1;
            if (Go) break;
        end
        check("go_seen", Go, 1'b1);
    endtask

    // Called in the START cycle; leaves TransferDone driven in the final byte/done cycle.
    task automatic send_bytes(input vec_t v);
        @(posedge clock); #1;
        check("go_one_cycle", Go, 1'b0);
        ByteValid    = 1'b1;
        ReceivedData = v.msb;
        @(posedge clock); #1;
        ReceivedData = v.lsb;
        TransferDone = v.same;
        if (!v.same) begin
            @(posedge clock); #1;
            if (v.extra) begin
                ReceivedData = 8'hAA;
                @(posedge clock); #1;
            end else begin
                ByteValid = 1'b0;
            end
            ByteValid    = 1'b0;
            TransferDone = 1'b1;
        end
    endtask

    task automatic finish_read(input vec_t v, input string tag);
        logic [11:0] prev_raw;
        int n;
        bit stable;
        prev_raw = RawTemp;
        n = 0;
        stable = 1;
        while (n < 20) begin
            @(posedge clock); #1;
            n++;
            ByteValid    = 1'b0;
            TransferDone = 1'b0;
            ReceivedData = 8'h00;
            if (SampleValid) break;
            if (RawTemp !== prev_raw) stable = 0;
        end
        check({tag, "_latency"}, n, 10);
        check({tag, "_hold"},    stable, 1'b1);
        check({tag, "_raw"},     RawTemp, v.raw);
        check({tag, "_sign"},    Sign, v.sign);
        check({tag, "_hund"},    HundredsBCD, v.h);
        check({tag, "_tens"},    TensBCD, v.t);
        check({tag, "_ones"},    OnesBCD, v.o);
        check({tag, "_tenths"},  TenthsBCD, exp_ten(v.ten));
        check({tag, "_tmoerr"},  TimeoutError, 1'b0);
        @(posedge clock); #1;
        check({tag, "_sv_pulse"}, SampleValid, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit sv;
        logic [11:0] held;

        vecs[0] = '{8'h19, 8'h00, 1'b0, 1'b0, 12'h190, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0};
        vecs[1] = '{8'hE7, 8'h00, 1'b0, 1'b0, 12'hE70, 1'b1, 4'd0, 4'd2, 4'd5, 4'd0};
        vecs[2] = '{8'h7F, 8'hF0, 1'b0, 1'b0, 12'h7FF, 1'b0, 4'd1, 4'd2, 4'd7, 4'd9};
        vecs[3] = '{8'h00, 8'h80, 1'b1, 1'b0, 12'h008, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5};
        vecs[4] = '{8'h80, 8'h00, 1'b0, 1'b0, 12'h800, 1'b1, 4'd1, 4'd2, 4'd8, 4'd0};
        vecs[5] = '{8'hFF, 8'hF0, 1'b1, 1'b0, 12'hFFF, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0};
        vecs[6] = '{8'h32, 8'h40, 1'b0, 1'b1, 12'h324, 1'b0, 4'd0, 4'd5, 4'd0, 4'd2};
        vecs[7] = '{8'hC9, 8'h80, 1'b0, 1'b0, 12'hC98, 1'b1, 4'd0, 4'd5, 4'd4, 4'd5};
        vecs[8] = '{8'h63, 8'h00, 1'b0, 1'b0, 12'h630, 1'b0, 4'd0, 4'd9, 4'd9, 4'd0};

        Reset = 1'b1; Enable = 1'b0; ByteValid = 1'b0; TransferDone = 1'b0; ReceivedData = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_go",   Go, 1'b0);
        check("rst_raw",  RawTemp, 12'h000);
        check("rst_sv",   SampleValid, 1'b0);
        check("rst_tmo",  TimeoutError, 1'b0);
        check("rst_digs", {Sign, HundredsBCD, TensBCD, OnesBCD, TenthsBCD}, 17'd0);

        Reset  = 1'b0;
        Enable = 1'b1;
        wait_go(n, sv);
        check("first_go_cycles", n, PERIOD);
        send_bytes(vecs[0]);
        finish_read(vecs[0], "v0");

        for (int i = 1; i < 9; i++) begin
            wait_go(n, sv);
            send_bytes(vecs[i]);
            finish_read(vecs[i], $sformatf("v%0d", i));
        end

        // No ByteValid after Go: timeout, outputs hold.
        wait_go(n, sv);
        held = RawTemp;
        n = 0;
        sv = 0;
        while (n < 200) begin
            @(posedge clock); #1;
            n++;
            if (SampleValid) sv = 1;
            if (TimeoutError) break;
        end
        check("tmo_cycles", n, Tmo + 1);
        check("tmo_no_sv",  sv, 1'b0);
        check("tmo_hold",   RawTemp, held);
        wait_go(n, sv);
        check("tmo_sticky", TimeoutError, 1'b1);
        send_bytes(vecs[2]);
        finish_read(vecs[2], "tmo_recover");

        // Short transfer: TransferDone while waiting for MSB.
        wait_go(n, sv);
        @(posedge clock); #1;
        TransferDone = 1'b1;
        @(posedge clock); #1;
        TransferDone = 1'b0;
        check("short_tmoerr", TimeoutError, 1'b1);
        check("short_no_sv",  SampleValid, 1'b0);
        check("short_hold",   RawTemp, vecs[2].raw);
        wait_go(n, sv);
        send_bytes(vecs[1]);
        finish_read(vecs[1], "short_recover");

        // Enable drops mid-read: read still publishes, then no further Go.
        wait_go(n, sv);
        Enable = 1'b0;
        send_bytes(vecs[8]);
        finish_read(vecs[8], "en_drop");
        sv = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clock); #1;
            if (Go) sv = 1;
        end
        check("en_off_no_go", sv, 1'b0);
        Enable = 1'b1;
        wait_go(n, sv);
        check("en_on_go_cycles", n, PERIOD);
        send_bytes(vecs[7]);
        finish_read(vecs[7], "en_back");

        // Reset asserted during BCD iterations.
        wait_go(n, sv);
        send_bytes(vecs[2]);
        repeat (3) begin
            @(posedge clock); #1;
            ByteValid    = 1'b0;
            TransferDone = 1'b0;
        end
        Reset = 1'b1;
        @(posedge clock); #1;
        Reset = 1'b0;
        check("mid_rst_raw",  RawTemp, 12'h000);
        check("mid_rst_digs", {Sign, HundredsBCD, TensBCD, OnesBCD, TenthsBCD}, 17'd0);
        check("mid_rst_flags", {Go, SampleValid, TimeoutError}, 3'b000);
        wait_go(n, sv);
        check("mid_rst_go_cycles", n, PERIOD);
        check("mid_rst_no_sv", sv, 1'b0);
        send_bytes(vecs[3]);
        finish_read(vecs[3], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
